// File: rtl/wcu_pkg.sv
// Shared worker package: FSM state encoding and Moore output decode for the
// worker control unit, importable by the top level and by benches.
package wcu_pkg;

  typedef logic [2:0] wcu_state_t;

  localparam wcu_state_t WCU_IDLE       = 3'd0;
  localparam wcu_state_t WCU_CONV_START = 3'd1;
  localparam wcu_state_t WCU_CONV_WAIT  = 3'd2;
  localparam wcu_state_t WCU_CALC_START = 3'd3;
  localparam wcu_state_t WCU_CALC_WAIT  = 3'd4;
  localparam wcu_state_t WCU_MC_WAIT    = 3'd5;
  localparam wcu_state_t WCU_DONE       = 3'd6;

  typedef struct packed {
    logic jw_ready;
    logic convert_start;
    logic calc_start;
    logic jw_done;
  } wcu_out_t;

  // Unused encodings decode to all-zero outputs.
  function automatic wcu_out_t wcu_decode(input wcu_state_t st);
    wcu_out_t o;
    o = '0;
    case (st)
      WCU_IDLE:       o.jw_ready      = 1'b1;
      WCU_CONV_START: o.convert_start = 1'b1;
      WCU_CALC_START: o.calc_start    = 1'b1;
      WCU_DONE:       o.jw_done       = 1'b1;
      default:        o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/wcu.sv
// Worker control unit: sequences converter, calculator and memory-controller
// handoff for one job at a time as a Moore FSM.
module wcu
  import wcu_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic JW_start,
  input  logic MC_busy,
  input  logic convert_done,
  input  logic calc_done,
  output logic JW_ready,
  output logic convert_start,
  output logic calc_start,
  output logic JW_done
);

  wcu_state_t state_q;
  wcu_state_t state_d;
  wcu_out_t   out_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= WCU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Done levels and MC_busy are only looked at in their own wait states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WCU_IDLE:       if (JW_start)      state_d = WCU_CONV_START;
      WCU_CONV_START:                    state_d = WCU_CONV_WAIT;
      WCU_CONV_WAIT:  if (convert_done)  state_d = WCU_CALC_START;
      WCU_CALC_START:                    state_d = WCU_CALC_WAIT;
      WCU_CALC_WAIT:  if (calc_done)     state_d = WCU_MC_WAIT;
      WCU_MC_WAIT:    if (!MC_busy)      state_d = WCU_DONE;
      WCU_DONE:                          state_d = WCU_IDLE;
      default:                           state_d = WCU_IDLE;
    endcase
  end

  always_comb begin
    out_d         = wcu_decode(state_q);
    JW_ready      = out_d.jw_ready;
    convert_start = out_d.convert_start;
    calc_start    = out_d.calc_start;
    JW_done       = out_d.jw_done;
  end

endmodule

// File: tb/tb_wcu.sv
// Bench for wcu: jobs are planned with explicit wait lengths, the expected
// pulse cycles are derived arithmetically and checked by a negedge monitor.
module tb_wcu;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic JW_start = 1'b0;
  logic MC_busy = 1'b0;
  logic convert_done = 1'b0;
  logic calc_done = 1'b0;
  logic JW_ready;
  logic convert_start;
  logic calc_start;
  logic JW_done;

  localparam int MAXC = 8192;
  localparam int K_CONV = 1;
  localparam int K_CALC = 2;
  localparam int K_DONE = 3;

  int cyc = 0;
  bit exp_busy [MAXC];
  logic [31:0] exp_q [$];
  int n_tests = 0;
  int n_fail = 0;
  bit mon_en = 1'b1;

  wcu dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .JW_start      (JW_start),
    .MC_busy       (MC_busy),
    .convert_done  (convert_done),
    .calc_done     (calc_done),
    .JW_ready      (JW_ready),
    .convert_start (convert_start),
    .calc_start    (calc_start),
    .JW_done       (JW_done)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ev(input int kind, input int c);
    logic [1:0]  k;
    logic [29:0] cc;
    k  = kind[1:0];
    cc = c[29:0];
    return {k, cc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, req);
    end
  endtask

  task automatic pop_cmp(input int kind);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_pulse kind %0d at cycle %0d: got pulse, want none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("pulse_kind_cycle", ev(kind, cyc), e);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      check("jw_ready", {31'b0, JW_ready}, {31'b0, !exp_busy[cyc % MAXC]});
      if (convert_start) pop_cmp(K_CONV);
      if (calc_start)    pop_cmp(K_CALC);
      if (JW_done)       pop_cmp(K_DONE);
    end
  end

  task automatic drive_idle();
    JW_start     = 1'b0;
    convert_done = 1'($urandom_range(0, 1));
    calc_done    = 1'($urandom_range(0, 1));
    MC_busy      = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  // a: CONV_WAIT cycles with convert_done low, b: same for calc_done,
  // m: MC_WAIT cycles with MC_busy high. abort_k >= 0 pulls reset in that
  // MC_WAIT cycle. Called in a cycle where the DUT is idle.
  task automatic run_job(input int a, input int b, input int m,
                         input bit quiet, input bit noisy, input int abort_k);
    int s, conv_s, conv_e, calc_s, calc_e, mc_s, mc_e, done_c, busy_e;
    s      = cyc;
    conv_s = s + 2;
    conv_e = conv_s + a;
    calc_s = conv_e + 2;
    calc_e = calc_s + b;
    mc_s   = calc_e + 1;
    mc_e   = mc_s + m;
    done_c = mc_e + 1;
    busy_e = (abort_k >= 0) ? (mc_s + abort_k - 1) : done_c;
    exp_q.push_back(ev(K_CONV, s + 1));
    exp_q.push_back(ev(K_CALC, conv_e + 1));
    if (abort_k < 0) exp_q.push_back(ev(K_DONE, done_c));
    for (int t = s + 1; t <= busy_e; t++) exp_busy[t % MAXC] = 1'b1;
    for (int t = s; t <= done_c; t++) begin
      JW_start = (t == s) ? 1'b1 : (noisy ? 1'b1 : 1'($urandom_range(0, 1)));
      if (t >= conv_s && t <= conv_e) convert_done = (t == conv_e);
      else convert_done = quiet ? 1'b1 : 1'($urandom_range(0, 1));
      if (t >= calc_s && t <= calc_e) calc_done = (t == calc_e);
      else calc_done = quiet ? 1'b1 : 1'($urandom_range(0, 1));
      if (t >= mc_s && t <= mc_e) MC_busy = (t != mc_e);
      else MC_busy = quiet ? 1'b0 : 1'($urandom_range(0, 1));
      if (abort_k >= 0 && t == mc_s + abort_k) begin
        #1;
        n_rst = 1'b0;
        #1;
        check("abort_ready", {31'b0, JW_ready}, 32'd1);
        check("abort_pulses", {29'b0, convert_start, calc_start, JW_done}, 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int a, b, m, k;
    // reset held, then released with JW_start low
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'b0, JW_ready}, 32'd1);
    check("reset_pulses", {29'b0, convert_start, calc_start, JW_done}, 32'd0);
    n_rst = 1'b1;
    drive_idle();
    drive_idle();
    check("post_reset_ready", {31'b0, JW_ready}, 32'd1);

    run_job(4, 0, 4, 1'b0, 1'b0, -1);   // nominal job
    drive_idle();
    run_job(0, 0, 0, 1'b1, 1'b0, -1);   // all satisfied: JW_done 6 cycles on
    drive_idle();
    run_job(1, 3, 2, 1'b0, 1'b1, -1);   // JW_start held high through the job
    run_job(2, 1, 5, 1'b0, 1'b0, 2);    // reset in MC_WAIT
    run_job(0, 0, 0, 1'b0, 1'b0, -1);   // accepted right after reset release
    run_job(0, 1, 20, 1'b0, 1'b0, -1);  // long MC_busy
    drive_idle();

    for (int j = 0; j < 40; j++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) drive_idle();
      a = $urandom_range(0, 5);
      b = $urandom_range(0, 5);
      m = $urandom_range(0, 6);
      k = (m > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, m - 1) : -1;
      run_job(a, b, m, 1'b0, ($urandom_range(0, 3) == 0), k);
    end

    repeat (3) drive_idle();
    mon_en = 1'b0;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wcu.md
WCU -- requirements
Module: wcu

Interface
REQ-001 The module SHALL have no parameters.
REQ-002 Port `clk`, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-003 Port `n_rst`, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port `JW_start`, input, 1 bit: a job-start request from the master; it SHALL be sampled only in IDLE.
REQ-005 Port `MC_busy`, input, 1 bit: the memory controller is busy; 0 means the result may be handed off.
REQ-006 Port `convert_done`, input, 1 bit: level from the coordinate converter meaning its conversion is complete.
REQ-007 Port `calc_done`, input, 1 bit: level from the iteration calculator meaning its calculation is complete.
REQ-008 Port `JW_ready`, output, 1 bit: the worker is idle and will accept `JW_start`.
REQ-009 Port `convert_start`, output, 1 bit: a one-cycle pulse that launches the converter.
REQ-010 Port `calc_start`, output, 1 bit: a one-cycle pulse that launches the calculator.
REQ-011 Port `JW_done`, output, 1 bit: a one-cycle pulse meaning the job is complete and the result has been handed off.

Function
REQ-012 The block SHALL be a Moore FSM with states IDLE, CONV_START, CONV_WAIT, CALC_START, CALC_WAIT, MC_WAIT and DONE.
REQ-013 All outputs SHALL be decoded from the registered state only, with no combinational path from any input to any output.
REQ-014 Output decode SHALL be:
- `JW_ready`=1 only in IDLE;
- `convert_start`=1 only in CONV_START;
- `calc_start`=1 only in CALC_START;
- `JW_done`=1 only in DONE;
- every output SHALL be 0 in every other state.
REQ-015 State transitions SHALL be:
- IDLE -> CONV_START when `JW_start`=1, otherwise stay in IDLE;
- CONV_START -> CONV_WAIT unconditionally.
REQ-016 State transitions SHALL continue:
- CONV_WAIT -> CALC_START when `convert_done`=1, otherwise stay;
- CALC_START -> CALC_WAIT unconditionally.
REQ-017 State transitions SHALL continue:
- CALC_WAIT -> MC_WAIT when `calc_done`=1, otherwise stay;
- MC_WAIT -> DONE when `MC_busy`=0, otherwise stay;
- DONE -> IDLE unconditionally.
REQ-018 `convert_done` and `calc_done` SHALL be level-sensitive and sampled only in their wait states.
- They MAY stay high indefinitely.
- A done level already high on entry to its wait state SHALL advance the FSM on the next edge, giving a minimum 1-cycle wait.
REQ-019 `JW_start` asserted in any state other than IDLE SHALL be ignored and SHALL NOT be queued.
REQ-020 `JW_start` held high through DONE SHALL start a new job one cycle after the return to IDLE.
REQ-021 With all inputs immediately satisfied, latency from the `JW_start` edge to the `JW_done` pulse SHALL be 6 cycles.
REQ-022 `MC_busy` SHALL be ignored outside MC_WAIT; a low pulse of one cycle in MC_WAIT SHALL suffice to advance.
REQ-023 Unreachable state encodings SHALL recover to IDLE on the next edge with all outputs 0.

Reset
REQ-024 `n_rst`=0 SHALL force IDLE asynchronously from any state, including mid-job, and SHALL abort any job in progress.
REQ-025 During reset, `JW_ready`=1 and `convert_start`=`calc_start`=`JW_done`=0.
REQ-026 After `n_rst` deasserts, the first `JW_start` SHALL be accepted on the next rising edge.

Structure
REQ-027 The state enumeration type SHALL reside in the shared worker package (e.g. `wcu_pkg`) so that the worker top level and benches can decode it.
REQ-028 The block SHALL be a single module with separate state-register and next-state/output-decode processes, and SHALL have no sub-modules.

Verification
REQ-029 Reset held, then released, with `JW_start`=0 -> IDLE, `JW_ready`=1, all pulse outputs 0.
REQ-030 Nominal job (the converter stays busy so `convert_done`=0 for 4 cycles, after which `convert_done`=1; `calc_done`=1 two cycles later; `MC_busy`=1 for 4 cycles, then 0 for 1 cycle) -> exactly one pulse each of `convert_start`, `calc_start` and `JW_done`, with `JW_ready`=0 throughout the job.
REQ-031 `convert_done`, `calc_done`=1 and `MC_busy`=0 held constant, `JW_start` pulsed -> `JW_done` fires 6 cycles after the `JW_start` edge.
REQ-032 `JW_start` pulsed during CALC_WAIT -> ignored, no second `convert_start`.
REQ-033 `n_rst` asserted during MC_WAIT -> immediate IDLE, no `JW_done` pulse.
REQ-034 `MC_busy` held 1 for 20 cycles in MC_WAIT -> the FSM holds there, then `JW_done` fires exactly 1 cycle after `MC_busy` falls.
